// File: rtl/gp_timer_arbiter.sv
// gp_timer_arbiter: round-robin sharing of one external gp_timer among NUM_REQ requesters.
// One requester is granted at a time; the block pulses the timer start and returns a done pulse on timeout.
module gp_timer_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_gnt_id,
  output logic [NUM_REQ-1:0] o_done,
  output logic               o_busy,
  output logic               o_tmr_start,
  input  logic               i_tmr_timeout
);

  typedef enum logic [1:0] {IDLE, ARM, WAIT, DONE} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] served_q, served_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic               busy_q, busy_d;
  logic               tmr_start_q, tmr_start_d;

  logic [NUM_REQ-1:0] eligible;
  logic               found;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    idx;

  // Round-robin search starting just after the last winner, wrapping around.
  always_comb begin
    eligible = i_req & ~served_q;
    found    = 1'b0;
    winner   = '0;
    idx      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(last_q) + k) % NUM_REQ);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    done_d      = '0;
    busy_d      = busy_q;
    tmr_start_d = 1'b0;
    last_d      = last_q;
    served_d    = served_q & i_req;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = ARM;
          gnt_d       = NUM_REQ'(1) << winner;
          gnt_id_d    = winner;
          last_d      = winner;
          tmr_start_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
      ARM: begin
        // A stale timeout from the previous run is deliberately not looked at here.
        if (!i_req[gnt_id_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!i_req[gnt_id_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end else if (i_tmr_timeout) begin
          state_d = DONE;
          done_d  = gnt_q;
        end
      end
      DONE: begin
        state_d  = IDLE;
        gnt_d    = '0;
        busy_d   = 1'b0;
        served_d = (served_q | gnt_q) & i_req;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      tmr_start_q <= 1'b0;
      last_q      <= ID_W'(NUM_REQ - 1);
      served_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      tmr_start_q <= tmr_start_d;
      last_q      <= last_d;
      served_q    <= served_d;
    end
  end

  assign o_gnt       = gnt_q;
  assign o_gnt_id    = gnt_id_q;
  assign o_done      = done_q;
  assign o_busy      = busy_q;
  assign o_tmr_start = tmr_start_q;

endmodule
